button_bcd_counter: RTL and testbench

BUTTON_BCD_COUNTER -- requirements
Module: button_bcd_counter

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/key_debouncer.sv | 47 ++++
 rtl/button_bcd_counter.sv | 91 +++++++++
 tb/tb_button_bcd_counter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared digit type, limits and wrap/saturate helpers for the pushbutton BCD counter.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  function automatic bcd_t bcd_sat(input logic [3:0] value);
    return (value > BCD_MAX) ? BCD_MAX : bcd_t'(value);
  endfunction

  function automatic bcd_t bcd_inc(input bcd_t value);
    return (value == BCD_MAX) ? BCD_MIN : bcd_t'(value + 4'd1);
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t value);
    return (value == BCD_MIN) ? BCD_MAX : bcd_t'(value - 4'd1);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One pushbutton: two-flop synchronizer, stable-level debouncer and a
// single-cycle pulse on each accepted press (stable 1 -> 0).
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Any return to the stable level restarts the count, so short glitches never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      stable_reg <= 1'b1;
      press_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
        press_reg  <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/button_bcd_counter.sv
// Single BCD digit stepped up/down by debounced pushbuttons, with a
// switch-driven saturating load that overrides the buttons.
module button_bcd_counter
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       load_en,
  input  logic [3:0] load_value,
  output logic [3:0] bcd,
  output logic       bcd_changed
);

  logic [1:0] keys_n;
  logic [1:0] press;

  logic       load_sync1_reg;
  logic       load_sync2_reg;
  logic [3:0] value_sync1_reg;
  logic [3:0] value_sync2_reg;

  bcd_t       bcd_reg;
  bcd_t       bcd_next;
  bcd_t       bcd_prev_reg;
  logic       changed_reg;

  // Index 0 is the up key, index 1 the down key.
  assign keys_n = {key_down_n, key_up_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (keys_n[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sync1_reg  <= 1'b0;
      load_sync2_reg  <= 1'b0;
      value_sync1_reg <= 4'd0;
      value_sync2_reg <= 4'd0;
    end else begin
      load_sync1_reg  <= load_en;
      load_sync2_reg  <= load_sync1_reg;
      value_sync1_reg <= load_value;
      value_sync2_reg <= value_sync1_reg;
    end
  end

  // Load wins outright; presses seen during a load are simply dropped.
  always_comb begin
    bcd_next = bcd_reg;
    if (load_sync2_reg) begin
      bcd_next = bcd_sat(value_sync2_reg);
    end else if (press[0] && !press[1]) begin
      bcd_next = bcd_inc(bcd_reg);
    end else if (press[1] && !press[0]) begin
      bcd_next = bcd_dec(bcd_reg);
    end
  end

  // The change flag compares the registered digit with its previous value,
  // so it lands one cycle after bcd moves and ignores same-value loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg      <= BCD_MIN;
      bcd_prev_reg <= BCD_MIN;
      changed_reg  <= 1'b0;
    end else begin
      bcd_reg      <= bcd_next;
      bcd_prev_reg <= bcd_reg;
      changed_reg  <= (bcd_reg != bcd_prev_reg);
    end
  end

  assign bcd         = bcd_reg;
  assign bcd_changed = changed_reg;

endmodule

// File: tb/tb_button_bcd_counter.sv
// Scoreboard bench: a sample-history reference model predicts every digit
// change; a negedge monitor pops predictions whenever bcd_changed fires.
module tb_button_bcd_counter;

  localparam int DC = 4;
  localparam int HD = DC + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_up_n = 1'b1;
  logic       key_down_n = 1'b1;
  logic       load_en = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] bcd;
  logic       bcd_changed;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  button_bcd_counter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_up_n    (key_up_n),
    .key_down_n  (key_down_n),
    .load_en     (load_en),
    .load_value  (load_value),
    .bcd         (bcd),
    .bcd_changed (bcd_changed)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t exp_q[$];
  bit   up_h[HD];
  bit   dn_h[HD];
  bit   ld_h[3];
  int   lv_h[3];
  bit   m_up_stable = 1'b1;
  bit   m_dn_stable = 1'b1;
  bit   m_up_p = 1'b0;
  bit   m_dn_p = 1'b0;
  int   m_bcd = 0;
  int   m_next;

  // A key level is accepted once DC consecutive samples, seen two clocks late, all oppose it.
  function automatic bit all_differ(input bit h[HD], input bit level);
    for (int i = 2; i < HD; i++) begin
      if (h[i] == level) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    for (int i = 0; i < HD; i++) begin
      up_h[i] = 1'b1;
      dn_h[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      ld_h[i] = 1'b0;
      lv_h[i] = 0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    for (int i = HD - 1; i > 0; i--) begin
      up_h[i] = up_h[i-1];
      dn_h[i] = dn_h[i-1];
    end
    for (int i = 2; i > 0; i--) begin
      ld_h[i] = ld_h[i-1];
      lv_h[i] = lv_h[i-1];
    end
    up_h[0] = key_up_n;
    dn_h[0] = key_down_n;
    ld_h[0] = load_en;
    lv_h[0] = int'(load_value);
    if (!rst_n) begin
      // Reset flushes the two-deep synchronizer history to idle.
      up_h[0] = 1'b1; up_h[1] = 1'b1;
      dn_h[0] = 1'b1; dn_h[1] = 1'b1;
      ld_h[0] = 1'b0; ld_h[1] = 1'b0;
      lv_h[0] = 0;    lv_h[1] = 0;
      m_up_stable = 1'b1;
      m_dn_stable = 1'b1;
      m_up_p = 1'b0;
      m_dn_p = 1'b0;
      m_bcd = 0;
      exp_q.delete();
    end else begin
      m_next = m_bcd;
      if (ld_h[2]) m_next = (lv_h[2] > 9) ? 9 : lv_h[2];
      else if (m_up_p && !m_dn_p) m_next = (m_bcd + 1) % 10;
      else if (m_dn_p && !m_up_p) m_next = (m_bcd + 9) % 10;
      if (m_next != m_bcd) exp_q.push_back(exp_t'{cyc + 1, m_next});
      m_bcd = m_next;
      m_up_p = 1'b0;
      m_dn_p = 1'b0;
      if (all_differ(up_h, m_up_stable)) begin
        m_up_stable = ~m_up_stable;
        m_up_p = ~m_up_stable;
      end
      if (all_differ(dn_h, m_dn_stable)) begin
        m_dn_stable = ~m_dn_stable;
        m_dn_p = ~m_dn_stable;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [3:0] last_bcd = 4'd0;
  bit         mon_exp_chg;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_exp_chg = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("bcd_changed_pulse", int'(bcd_changed), int'(mon_exp_chg));
      if (mon_exp_chg) begin
        check("bcd_value_at_change", int'(last_bcd), exp_q[0].val);
        void'(exp_q.pop_front());
      end
      check("bcd_vs_model", int'(bcd), m_bcd);
    end
    last_bcd = bcd;
  end

  // ---------------- stimulus ----------------
  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input int v);
    load_en = 1'b1;
    load_value = 4'(v);
    steps(3);
    load_en = 1'b0;
    steps(3);
  endtask

  task automatic press(input bit up, input bit dn);
    if (up) key_up_n = 1'b0;
    if (dn) key_down_n = 1'b0;
    steps(DC + 3);
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    steps(DC + 4);
  endtask

  // Waits (bounded) for bcd_changed and returns the cycles elapsed since start.
  task automatic wait_changed(input int start, output int delta);
    delta = -1;
    for (int k = 0; k < 20; k++) begin
      steps(1);
      if (bcd_changed) begin
        delta = cyc - start;
        break;
      end
    end
  endtask

  int t0;
  int dl;
  int up_left = 0, dn_left = 0, ld_left = 0;

  initial begin
    steps(3);
    check("reset_bcd", int'(bcd), 0);
    check("reset_changed", int'(bcd_changed), 0);
    rst_n = 1'b1;
    steps(5);

    // Press latency: low from cycle c -> change flag in cycle c+8.
    key_up_n = 1'b0;
    t0 = cyc;
    wait_changed(t0, dl);
    check("press_latency", dl, DC + 4);
    check("first_step_bcd", int'(bcd), 1);
    steps(1);
    check("changed_one_cycle", int'(bcd_changed), 0);
    steps(DC);
    check("hold_single_step", int'(bcd), 1);
    key_up_n = 1'b1;
    steps(DC + 4);

    do_load(9);
    press(1'b1, 1'b0);
    check("wrap_9_to_0", int'(bcd), 0);
    press(1'b0, 1'b1);
    check("wrap_0_to_9", int'(bcd), 9);

    // Glitchy press never holds for DC samples.
    key_up_n = 1'b0; steps(3);
    key_up_n = 1'b1; steps(1);
    key_up_n = 1'b0; steps(3);
    key_up_n = 1'b1; steps(10);
    check("glitch_ignored", int'(bcd), 9);

    do_load(5);
    press(1'b1, 1'b1);
    check("both_cancel", int'(bcd), 5);

    load_en = 1'b1;
    load_value = 4'd12;
    steps(4);
    check("load_saturates", int'(bcd), 9);
    press(1'b1, 1'b0);
    check("press_during_load", int'(bcd), 9);
    load_en = 1'b0;
    steps(3);
    do_load(9);
    check("reload_same", int'(bcd), 9);

    // Reset two cycles into a debounce with the key still held.
    do_load(7);
    check("preload_7", int'(bcd), 7);
    key_up_n = 1'b0;
    steps(2);
    rst_n = 1'b0;
    #1;
    check("async_reset_bcd", int'(bcd), 0);
    check("async_reset_changed", int'(bcd_changed), 0);
    steps(1);
    rst_n = 1'b1;
    t0 = cyc;
    wait_changed(t0, dl);
    check("post_reset_latency", dl, DC + 4);
    check("post_reset_bcd", int'(bcd), 1);
    key_up_n = 1'b1;
    steps(DC + 4);

    // Randomized level-hold stimulus on all inputs.
    for (int n = 0; n < 600; n++) begin
      if (up_left == 0) begin
        key_up_n = 1'($urandom_range(0, 1));
        up_left = $urandom_range(1, 9);
      end
      if (dn_left == 0) begin
        key_down_n = 1'($urandom_range(0, 1));
        dn_left = $urandom_range(1, 9);
      end
      if (ld_left == 0) begin
        load_en = ($urandom_range(0, 5) == 0);
        load_value = 4'($urandom_range(0, 15));
        ld_left = $urandom_range(1, 6);
      end
      up_left--;
      dn_left--;
      ld_left--;
      steps(1);
    end
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    load_en = 1'b0;
    steps(20);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
